// File: rtl/seg_pkg.sv
// Shared constants and state encoding for the segment parallel-to-serial shifter.
package seg_pkg;

    localparam int unsigned SEG_FRAME_W = 64;  // 8 digits x 8 segment bits
    localparam int unsigned SEG_CLK_DIV = 4;   // clk cycles per SEG_CLK half-period

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } seg_state_e;

endpackage

// File: rtl/seg_tick_gen.sv
// Half-period timer for SEG_CLK: counts 0..CLK_DIV-1 and flags the last cycle.
// Ports:
//   clk, rst_n   - system clock, synchronous active-low reset
//   clr          - synchronous restart of the count (accept / phase change)
//   phase_end_c  - high in the last cycle of the current half-period
module seg_tick_gen
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV = SEG_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic phase_end_c
);

    // One bit minimum so CLK_DIV=1 still elaborates; the count then stays 0.
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (phase_end_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign phase_end_c = (cnt == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/seg_p2s_shifter.sv
// Shifts a hex-decoded segment frame MSB-first into an external
// 74HC164-style chain, with a start/busy/done handshake upstream.
// Ports:
//   clk, rst_n  - system clock, synchronous active-low reset
//   start, data - frame request and payload, sampled while idle
//   busy, done  - frame in progress / one-cycle completion pulse
//   SEG_CLK     - serial clock, chain shifts on its rising edge
//   SEG_DO      - serial data, stable through each SEG_CLK high phase
//   SEG_CLR     - chain clear (active-low), SEG_EN - display enable
module seg_p2s_shifter
    import seg_pkg::*;
#(
    parameter int unsigned DATA_W  = SEG_FRAME_W,
    parameter int unsigned CLK_DIV = SEG_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              SEG_CLK,
    output logic              SEG_DO,
    output logic              SEG_CLR,
    output logic              SEG_EN
);

    localparam int unsigned BCNT_W = $clog2(DATA_W + 1);

    seg_state_e        state, state_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [BCNT_W-1:0] bcnt, bcnt_d;
    logic              busy_d, done_d, seg_clk_d, seg_do_d;
    logic              seg_on;
    logic              tick_clr_c;
    logic              phase_end_c;

    seg_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (tick_clr_c),
        .phase_end_c (phase_end_c)
    );

    // Next-state and next-output logic; outputs are computed one cycle
    // ahead so every port comes straight from a flop.
    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bcnt_d     = bcnt;
        busy_d     = busy;
        done_d     = 1'b0;
        seg_clk_d  = SEG_CLK;
        seg_do_d   = SEG_DO;
        tick_clr_c = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOW;
                    shreg_d    = data;
                    bcnt_d     = BCNT_W'(DATA_W);
                    busy_d     = 1'b1;
                    seg_clk_d  = 1'b0;
                    seg_do_d   = data[DATA_W-1];
                    tick_clr_c = 1'b1;
                end
            end

            ST_LOW: begin
                seg_do_d = shreg[DATA_W-1];
                if (phase_end_c) begin
                    state_d    = ST_HIGH;
                    seg_clk_d  = 1'b1;
                    tick_clr_c = 1'b1;
                end
            end

            ST_HIGH: begin
                if (phase_end_c) begin
                    shreg_d    = {shreg[DATA_W-2:0], 1'b0};
                    bcnt_d     = bcnt - BCNT_W'(1);
                    tick_clr_c = 1'b1;
                    if (bcnt == BCNT_W'(1)) begin
                        // Last bit: SEG_CLK and SEG_DO hold, so the line
                        // stays high into a back-to-back frame.
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_LOW;
                        seg_clk_d = 1'b0;
                        seg_do_d  = shreg[DATA_W-2];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bcnt    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            SEG_CLK <= 1'b1;
            SEG_DO  <= 1'b0;
            seg_on  <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bcnt    <= bcnt_d;
            busy    <= busy_d;
            done    <= done_d;
            SEG_CLK <= seg_clk_d;
            SEG_DO  <= seg_do_d;
            seg_on  <= 1'b1;
        end
    end

    assign SEG_CLR = seg_on;
    assign SEG_EN  = seg_on;

endmodule

// File: tb/tb_seg_p2s_shifter.sv
// Self-checking bench for seg_p2s_shifter at CLK_DIV=2 and CLK_DIV=1.
module tb_seg_p2s_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start2, start1;
    logic [63:0] data2, data1;
    logic        busy2, done2, sclk2, sdo2, sclr2, sen2;
    logic        busy1, done1, sclk1, sdo1, sclr1, sen1;

    bit          sel;  // 0: CLK_DIV=2 instance, 1: CLK_DIV=1 instance
    logic        o_busy, o_done, o_clk, o_do, o_clr, o_en;

    int npass = 0;
    int nchk  = 0;

    always #5 clk = ~clk;

    seg_p2s_shifter #(.DATA_W(64), .CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .data(data2),
        .busy(busy2), .done(done2), .SEG_CLK(sclk2), .SEG_DO(sdo2),
        .SEG_CLR(sclr2), .SEG_EN(sen2)
    );

    seg_p2s_shifter #(.DATA_W(64), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .data(data1),
        .busy(busy1), .done(done1), .SEG_CLK(sclk1), .SEG_DO(sdo1),
        .SEG_CLR(sclr1), .SEG_EN(sen1)
    );

    always_comb begin
        o_busy = sel ? busy1 : busy2;
        o_done = sel ? done1 : done2;
        o_clk  = sel ? sclk1 : sclk2;
        o_do   = sel ? sdo1  : sdo2;
        o_clr  = sel ? sclr1 : sclr2;
        o_en   = sel ? sen1  : sen2;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic set_in(input logic s, input logic [63:0] d);
        if (sel) begin start1 = s; data1 = d; end
        else     begin start2 = s; data2 = d; end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Observe one frame whose start was presented at the previous edge.
    // Reference: the chain must receive d MSB-first, one bit per SEG_CLK
    // rise, over 2*div*64 busy cycles, with done in the cycle after.
    task automatic collect(input logic [63:0] d, input int div, input bit inject,
                           input bit b2b, input logic [63:0] nd);
        logic [63:0] rx = '0;
        logic        pclk = 1'b1;
        logic        held = 1'b0;
        int          bcnt = 0, rises = 0, tog = 0, dcyc = 0, cyc = 0, unstable = 0;
        bit          seen = 0;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (o_clk !== pclk) tog++;
            if (o_clk === 1'b1 && pclk === 1'b0) begin
                rises++;
                rx   = {rx[62:0], o_do};
                held = o_do;
            end else if (o_busy === 1'b1 && o_clk === 1'b1 && o_do !== held) begin
                unstable++;
            end
            pclk = o_clk;
            if (o_busy === 1'b1) bcnt++;
            if (o_done === 1'b1) begin seen = 1; dcyc = cyc; end
            if (inject && cyc == 50)      set_in(1'b1, '1);
            else                          set_in(1'b0, rnd64());
        end
        chk("done_seen",   64'(seen),  64'd1);
        chk("stream",      rx,         d);
        chk("rises",       64'(rises), 64'd64);
        chk("toggles",     64'(tog),   64'd128);
        chk("busy_cycles", 64'(bcnt),  64'(2 * div * 64));
        chk("done_cycle",  64'(dcyc),  64'(2 * div * 64 + 1));
        chk("do_stable",   64'(unstable), 64'd0);
        if (div == 1) chk("toggle_every_cycle", 64'(tog), 64'(bcnt));
        if (b2b) set_in(1'b1, nd);
    endtask

    // Idle after a frame: no further done, clock parked high, last bit held.
    task automatic idle_check(input logic lastbit);
        int extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_busy === 1'b1) extra++;
        end
        chk("idle_no_done", 64'(extra), 64'd0);
        chk("idle_clk",     64'(o_clk), 64'd1);
        chk("idle_do",      64'(o_do),  64'(lastbit));
    endtask

    initial begin
        logic [63:0] r, q;
        int          rises, cyc;
        logic        pclk;

        sel    = 1'b0;
        rst_n  = 1'b0;
        start1 = 1'b0; data1 = '0;
        start2 = 1'b1; data2 = rnd64();

        // Reset with start held high.
        repeat (3) begin
            @(negedge clk);
            chk("rst_clk",  64'(o_clk),  64'd1);
            chk("rst_do",   64'(o_do),   64'd0);
            chk("rst_clr",  64'(o_clr),  64'd0);
            chk("rst_en",   64'(o_en),   64'd0);
            chk("rst_busy", 64'(o_busy), 64'd0);
            chk("rst_done", 64'(o_done), 64'd0);
        end
        rst_n  = 1'b1;
        start2 = 1'b0;
        @(negedge clk);
        chk("post_rst_clr",  64'(o_clr),  64'd1);
        chk("post_rst_en",   64'(o_en),   64'd1);
        chk("post_rst_busy", 64'(o_busy), 64'd0);
        chk("post_rst_clk",  64'(o_clk),  64'd1);

        // Single frame, first and last bit set.
        set_in(1'b1, 64'h8000_0000_0000_0001);
        collect(64'h8000_0000_0000_0001, 2, 1'b0, 1'b0, '0);
        idle_check(1'b1);

        // Start while busy must be ignored.
        set_in(1'b1, 64'h0);
        collect(64'h0, 2, 1'b1, 1'b0, '0);
        idle_check(1'b0);

        // Random frame, then back-to-back frame started in the done cycle.
        r = rnd64();
        set_in(1'b1, r);
        collect(r, 2, 1'b0, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5);
        collect(64'hA5A5_A5A5_A5A5_A5A5, 2, 1'b0, 1'b0, '0);
        idle_check(1'b1);

        // Reset after the 10th SEG_CLK rise aborts without a done.
        r = rnd64();
        set_in(1'b1, r);
        rises = 0; cyc = 0; pclk = 1'b1;
        while (rises < 10 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (o_clk === 1'b1 && pclk === 1'b0) rises++;
            pclk = o_clk;
            set_in(1'b0, rnd64());
        end
        chk("mid_rises", 64'(rises), 64'd10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_clk",  64'(o_clk),  64'd1);
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_done", 64'(o_done), 64'd0);
        chk("abort_do",   64'(o_do),   64'd0);
        rst_n = 1'b1;
        idle_check(1'b0);

        // A full frame after the abort.
        r = rnd64();
        set_in(1'b1, r);
        collect(r, 2, 1'b0, 1'b0, '0);
        idle_check(r[0]);

        // CLK_DIV=1 instance.
        sel = 1'b1;
        set_in(1'b1, 64'h0123_4567_89AB_CDEF);
        collect(64'h0123_4567_89AB_CDEF, 1, 1'b0, 1'b0, '0);
        idle_check(1'b1);

        r = rnd64();
        q = rnd64();
        set_in(1'b1, r);
        collect(r, 1, 1'b1, 1'b1, q);
        collect(q, 1, 1'b0, 1'b0, '0);
        idle_check(q[0]);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/seg_p2s_shifter.md
Name: seg_p2s_shifter

Overview:
- Parallel-to-serial stage that takes a 64-bit segment pattern (8 digits x 8 segment bits, already hex-decoded) and shifts it into the board's external 74HC164-style seven-segment shift-register chain.
- Drives SEG_CLK / SEG_DO / SEG_CLR / SEG_EN.
- Sits directly downstream of the hex-to-segment encoder. Fed by a refresh controller through a start/busy/done handshake.

Parameters:
- DATA_W, 64, bits per frame; must be even and >= 2.
- CLK_DIV, 4, clk cycles per SEG_CLK half-period; must be >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  request to shift one frame; sampled only when busy=0
- data  in  DATA_W  frame to shift; bit DATA_W-1 is sent first; captured on the accept cycle
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when the frame is complete
- SEG_CLK  out  1  serial clock; external register shifts on its rising edge
- SEG_DO  out  1  serial data; stable for the whole SEG_CLK high phase
- SEG_CLR  out  1  external register clear, active-low
- SEG_EN  out  1  display enable, active-high

Behaviour:
- Reset (rst_n=0 at a clk edge) gives: busy=0, done=0, SEG_CLK=1, SEG_DO=0, SEG_CLR=0, SEG_EN=0, state IDLE, shift register 0, counters 0.
- After reset: SEG_CLR=1 and SEG_EN=1 from the first edge with rst_n=1, held constant thereafter.
- States: IDLE, LOW, HIGH.
- IDLE:
  - SEG_CLK=1, busy=0.
  - start=1 is accepted: data is loaded into the shift register, bit counter is set to DATA_W, divider is cleared, next state is LOW.
- LOW:
  - From the cycle after accept: busy=1, SEG_CLK=0, SEG_DO=shreg[DATA_W-1].
  - Lasts exactly CLK_DIV cycles, then goes to HIGH.
- HIGH:
  - SEG_CLK=1 and SEG_DO is unchanged.
  - Lasts exactly CLK_DIV cycles.
  - At its end: shreg shifts left by 1 with 0 fill, and the bit counter decrements.
  - If the counter reaches 0, go to IDLE; otherwise go to LOW.
- Latency: busy is high for exactly 2*CLK_DIV*DATA_W cycles.
- done is a 1-cycle pulse in the first IDLE cycle after the last HIGH phase; busy falls in that same cycle.
- start with busy=1 is ignored, and data changes mid-frame have no effect.
- start in the done cycle is accepted (back-to-back frames), giving no SEG_CLK glitch: SEG_CLK stays 1 then goes low normally.
- Reset mid-frame aborts at the next edge: all outputs take their reset values and no done pulse is issued.
- All outputs are registered, with no combinational path from inputs to outputs.
- After idle, SEG_DO holds the last shifted bit.

Decomposition:
- Package seg_pkg:
  - SEG_FRAME_W=64 and SEG_CLK_DIV default
  - state enum {IDLE, LOW, HIGH}
- One natural sub-module, seg_tick_gen:
  - Counts 0..CLK_DIV-1 and emits a phase_end pulse.
  - Has a synchronous clear driven on accept and on each phase transition.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> SEG_CLK=1, SEG_DO=0, SEG_CLR=0, SEG_EN=0, busy=0, done=0. First edge after release -> SEG_CLR=1, SEG_EN=1.
- Single frame with CLK_DIV=2, data=64'h8000_0000_0000_0001, one-cycle start:
  - busy high for exactly 256 cycles and 64 SEG_CLK rising edges.
  - SEG_DO sampled on those edges reads 1, 62x 0, 1.
  - done pulses once in cycle 257 after accept.
- Start while busy: second start=1 with data=64'hFFFF_FFFF_FFFF_FFFF at cycle 50 of a frame carrying 64'h0 -> ignored. All 64 sampled bits are 0 and only one done is produced.
- Back-to-back: start asserted in the done cycle with data=64'hA5A5_A5A5_A5A5_A5A5 -> new frame begins the next cycle. Sampled stream is 1010_0101 repeated, and SEG_CLK shows no extra edge.
- Reset mid-frame: rst_n=0 for 1 cycle after the 10th SEG_CLK rising edge -> next edge gives SEG_CLK=1, busy=0, no done pulse. A new start then sends a full 64-bit frame correctly.
- CLK_DIV=1, data=64'h0123_4567_89AB_CDEF -> 128-cycle busy. SEG_CLK toggles every cycle and the sampled stream matches data MSB-first.
